// File: rtl/mux41_pkg.sv
// Shared types, sizes and the round-robin pick helper for the 4:1 select scheduler.
package mux41_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First set request searching last+1, last+2, last+3, last+4 (mod 4).
  // Walks the offsets from farthest to nearest so the nearest hit is the one kept.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] last);
    pick_t            r;
    logic [SEL_W-1:0] cand;
    r = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        r.found = 1'b1;
        r.idx   = cand;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux41_rr_sched_if.sv
// Request/data/grant bundle between the requesters and the scheduler.
interface mux41_rr_sched_if;
  import mux41_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] c;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] s;
  logic             z;
  logic             z_valid;
  logic             busy;

  modport master (output req, c, input gnt, s, z, z_valid, busy);
  modport slave  (input req, c, output gnt, s, z, z_valid, busy);
endinterface

// File: rtl/mux41_sel.sv
// Pure 4:1 bit select of c by the current owner index.
module mux41_sel
  import mux41_pkg::*;
(
  input  logic [N_REQ-1:0] c,
  input  logic [SEL_W-1:0] sel,
  output logic             z
);

  logic [N_REQ-1:0] hit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hit
    assign hit[gi] = c[gi] & (sel == SEL_W'(gi));
  end

  assign z = |hit;

endmodule

// File: rtl/mux41_rr_sched.sv
// Round-robin owner of a shared 4:1 select path: bounded bursts, idle gap, registered z.
module mux41_rr_sched
  import mux41_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int GAP_CYC  = 1,
  parameter int HOLD_W   = 8
) (
  input logic             clk,
  input logic             rst,
  mux41_rr_sched_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD);
  localparam logic [3:0]        GAP_LAST  = 4'(GAP_CYC - 1);
  localparam bit                GAP_NONE  = (GAP_CYC == 0);

  sched_state_e     state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [SEL_W-1:0] s_reg, s_next;
  logic [SEL_W-1:0] last_owner_reg, last_owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0]       gap_cnt_reg, gap_cnt_next;
  logic             z_reg, z_next;
  logic             z_valid_reg, z_valid_next;
  logic             grant_now;
  logic             sel_bit;
  pick_t            pick;

  // s_reg is the owner while in GRANT, so it drives the select directly.
  mux41_sel u_sel (
    .c   (bus.c),
    .sel (s_reg),
    .z   (sel_bit)
  );

  assign pick = rr_pick(bus.req, last_owner_reg);

  // State register and all registered outputs; reset is immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      s_reg          <= '0;
      last_owner_reg <= SEL_W'(N_REQ - 1);
      hold_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      z_reg          <= 1'b0;
      z_valid_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      s_reg          <= s_next;
      last_owner_reg <= last_owner_next;
      hold_cnt_reg   <= hold_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      z_reg          <= z_next;
      z_valid_reg    <= z_valid_next;
    end
  end

  // Next-state logic; a grant decided in any state is applied at the bottom.
  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    s_next          = s_reg;
    last_owner_next = last_owner_reg;
    hold_cnt_next   = hold_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    z_next          = z_reg;
    z_valid_next    = 1'b0;
    grant_now       = 1'b0;

    case (state_reg)
      IDLE: begin
        grant_now = pick.found;
      end
      GRANT: begin
        z_next       = sel_bit;
        z_valid_next = bus.req[s_reg];
        if (!bus.req[s_reg] || hold_cnt_reg == HOLD_LAST) begin
          gnt_next = '0;
          if (GAP_NONE) begin
            // No gap: re-arbitrate now; last_owner already equals the outgoing owner.
            grant_now = pick.found;
            if (!pick.found) state_next = IDLE;
          end else begin
            state_next   = GAP;
            gap_cnt_next = '0;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt_reg + 4'd1;
        if (gap_cnt_reg == GAP_LAST) begin
          grant_now = pick.found;
          if (!pick.found) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase

    if (grant_now) begin
      state_next      = GRANT;
      s_next          = pick.idx;
      gnt_next        = N_REQ'(1) << pick.idx;
      hold_cnt_next   = HOLD_W'(1);
      last_owner_next = pick.idx;
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.s       = s_reg;
  assign bus.z       = z_reg;
  assign bus.z_valid = z_valid_reg;
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mux41_rr_sched.sv
// Bench for mux41_rr_sched: five parameter sets share one stimulus stream and are
// compared every cycle against a behavioural owner/gap model, plus directed checks.
module tb_mux41_rr_sched;
  import mux41_pkg::*;

  localparam int ND = 5;
  int mh_p [ND] = '{8, 2, 1, 2, 3};
  int gc_p [ND] = '{1, 1, 1, 0, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_v = 4'b0;
  logic [3:0] c_v = 4'b0;
  int         checks = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  mux41_rr_sched_if i0 ();
  mux41_rr_sched_if i1 ();
  mux41_rr_sched_if i2 ();
  mux41_rr_sched_if i3 ();
  mux41_rr_sched_if i4 ();
  assign i0.req = req_v;  assign i0.c = c_v;
  assign i1.req = req_v;  assign i1.c = c_v;
  assign i2.req = req_v;  assign i2.c = c_v;
  assign i3.req = req_v;  assign i3.c = c_v;
  assign i4.req = req_v;  assign i4.c = c_v;

  mux41_rr_sched #(.MAX_HOLD(8), .GAP_CYC(1), .HOLD_W(8)) u0 (.clk(clk), .rst(rst), .bus(i0));
  mux41_rr_sched #(.MAX_HOLD(2), .GAP_CYC(1), .HOLD_W(8)) u1 (.clk(clk), .rst(rst), .bus(i1));
  mux41_rr_sched #(.MAX_HOLD(1), .GAP_CYC(1), .HOLD_W(8)) u2 (.clk(clk), .rst(rst), .bus(i2));
  mux41_rr_sched #(.MAX_HOLD(2), .GAP_CYC(0), .HOLD_W(8)) u3 (.clk(clk), .rst(rst), .bus(i3));
  mux41_rr_sched #(.MAX_HOLD(3), .GAP_CYC(3), .HOLD_W(8)) u4 (.clk(clk), .rst(rst), .bus(i4));

  // Model: owner (-1 = nobody), cycles held, gap cycles still to run, rotation pointer.
  int   m_owner [ND];
  int   m_held  [ND];
  int   m_gap   [ND];
  int   m_last  [ND];
  int   m_s     [ND];
  logic m_z     [ND];
  logic m_zv    [ND];

  function void m_reset();
    for (int d = 0; d < ND; d++) begin
      m_owner[d] = -1; m_held[d] = 0; m_gap[d] = 0; m_last[d] = 3;
      m_s[d] = 0; m_z[d] = 1'b0; m_zv[d] = 1'b0;
    end
  endfunction

  function void m_arb(int d, logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (m_last[d] + k) % 4;
      if (r[i]) begin
        m_owner[d] = i; m_held[d] = 1; m_last[d] = i; m_s[d] = i;
        return;
      end
    end
  endfunction

  function void m_step(logic [3:0] r, logic [3:0] cc);
    for (int d = 0; d < ND; d++) begin
      if (m_owner[d] >= 0) begin
        m_z[d]  = cc[m_owner[d]];
        m_zv[d] = r[m_owner[d]];
        if (!r[m_owner[d]] || m_held[d] == mh_p[d]) begin
          m_owner[d] = -1;
          if (gc_p[d] == 0) m_arb(d, r);
          else m_gap[d] = gc_p[d];
        end else begin
          m_held[d]++;
        end
      end else begin
        m_zv[d] = 1'b0;
        if (m_gap[d] > 0) begin
          m_gap[d]--;
          if (m_gap[d] == 0) m_arb(d, r);
        end else begin
          m_arb(d, r);
        end
      end
    end
  endfunction

  // {gnt, s, z, z_valid, busy}
  function logic [8:0] exp_vec(int d);
    logic [3:0] g;
    logic [1:0] sv;
    g = 4'b0;
    if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
    sv = 2'(m_s[d]);
    return {g, sv, m_z[d], m_zv[d], (m_owner[d] >= 0) || (m_gap[d] > 0)};
  endfunction

  function logic [8:0] get_act(int d);
    case (d)
      0:       return {i0.gnt, i0.s, i0.z, i0.z_valid, i0.busy};
      1:       return {i1.gnt, i1.s, i1.z, i1.z_valid, i1.busy};
      2:       return {i2.gnt, i2.s, i2.z, i2.z_valid, i2.busy};
      3:       return {i3.gnt, i3.s, i3.z, i3.z_valid, i3.busy};
      default: return {i4.gnt, i4.s, i4.z, i4.z_valid, i4.busy};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step(req_v, c_v);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    m_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (get_act(d) !== 9'b0) $display("FAIL reset dut%0d got=%b need=%b", d, get_act(d), 9'b0);
      else passes++;
    end
    #10;
    rst = 1'b0;
  endtask

  task automatic test_single_hold();
    do_reset();
    req_v = 4'b0001;
    for (int i = 0; i < 24; i++) begin
      c_v = 4'($urandom);
      tick();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (get_act(d) !== exp_vec(d))
          $display("FAIL single_model dut%0d t=%0t got=%b need=%b", d, $time, get_act(d), exp_vec(d));
        else passes++;
      end
      if (i < 12) begin
        checks++;
        if (i0.gnt !== ((i == 8) ? 4'b0000 : 4'b0001))
          $display("FAIL single_gnt cyc%0d got=%b need=%b", i, i0.gnt, (i == 8) ? 4'b0000 : 4'b0001);
        else passes++;
      end
      if (i < 10) begin
        checks++;
        if (i0.z_valid !== (i >= 1 && i <= 8))
          $display("FAIL single_zv cyc%0d got=%b need=%b", i, i0.z_valid, (i >= 1 && i <= 8));
        else passes++;
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] want;
    do_reset();
    req_v = 4'b1111;
    for (int i = 0; i < 15; i++) begin
      c_v = 4'($urandom);
      tick();
      want = ((i % 3) < 2) ? (4'b0001 << ((i / 3) % 4)) : 4'b0000;
      checks++;
      if (i1.gnt !== want) $display("FAIL rotation_gnt cyc%0d got=%b need=%b", i, i1.gnt, want);
      else passes++;
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (get_act(d) !== exp_vec(d))
          $display("FAIL rotation_model dut%0d t=%0t got=%b need=%b", d, $time, get_act(d), exp_vec(d));
        else passes++;
      end
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    req_v = 4'b0100;
    c_v   = 4'b0100;
    tick();
    for (int i = 1; i <= 6; i++) begin
      tick();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (get_act(d) !== exp_vec(d))
          $display("FAIL drop_model dut%0d t=%0t got=%b need=%b", d, $time, get_act(d), exp_vec(d));
        else passes++;
      end
      if (i == 2 || i == 3) begin
        checks++;
        if ({i0.gnt, i0.z, i0.z_valid} !== 6'b0100_1_1)
          $display("FAIL drop_hold cyc%0d got=%b need=%b", i, {i0.gnt, i0.z, i0.z_valid}, 6'b0100_1_1);
        else passes++;
      end
      if (i == 4) begin
        checks++;
        if ({i0.gnt, i0.z, i0.z_valid, i0.busy} !== 7'b0000_1_0_1)
          $display("FAIL drop_clear got=%b need=%b", {i0.gnt, i0.z, i0.z_valid, i0.busy}, 7'b0000_1_0_1);
        else passes++;
      end
      if (i == 5) begin
        checks++;
        if (i0.busy !== 1'b0) $display("FAIL drop_idle busy got=%b need=0", i0.busy);
        else passes++;
      end
      if (i == 3) req_v = 4'b0000;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want;
    do_reset();
    req_v = 4'b0110;
    for (int i = 0; i < 12; i++) begin
      c_v = 4'($urandom);
      tick();
      want = (((i / 2) % 2) == 0) ? 4'b0010 : 4'b0100;
      checks++;
      if (i3.gnt !== want) $display("FAIL b2b_gnt cyc%0d got=%b need=%b", i, i3.gnt, want);
      else passes++;
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (get_act(d) !== exp_vec(d))
          $display("FAIL b2b_model dut%0d t=%0t got=%b need=%b", d, $time, get_act(d), exp_vec(d));
        else passes++;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_v = 4'b1000;
    tick();
    tick();
    checks++;
    if (i0.gnt !== 4'b1000) $display("FAIL areset_pre got=%b need=1000", i0.gnt);
    else passes++;
    #1;
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (get_act(d) !== 9'b0) $display("FAIL areset_now dut%0d got=%b need=%b", d, get_act(d), 9'b0);
      else passes++;
    end
    rst = 1'b0;
    m_reset();
    req_v = 4'b1001;
    tick();
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (get_act(d) !== exp_vec(d) || get_act(d)[8:5] !== 4'b0001)
        $display("FAIL areset_after dut%0d got=%b need gnt=0001 vec=%b", d, get_act(d), exp_vec(d));
      else passes++;
    end
  endtask

  task automatic test_hold_one();
    logic [3:0] c_edge;
    do_reset();
    req_v = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      c_edge = c_v;
      tick();
      checks++;
      if (i2.gnt !== ((i % 2 == 0) ? 4'b0010 : 4'b0000))
        $display("FAIL hold1_gnt cyc%0d got=%b need=%b", i, i2.gnt, (i % 2 == 0) ? 4'b0010 : 4'b0000);
      else passes++;
      if (i % 2 == 1) begin
        checks++;
        if ({i2.z_valid, i2.z} !== {1'b1, c_edge[1]})
          $display("FAIL hold1_z cyc%0d got=%b need=%b", i, {i2.z_valid, i2.z}, {1'b1, c_edge[1]});
        else passes++;
      end
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (get_act(d) !== exp_vec(d))
          $display("FAIL hold1_model dut%0d t=%0t got=%b need=%b", d, $time, get_act(d), exp_vec(d));
        else passes++;
      end
      c_v = 4'($urandom);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req_v = 4'($urandom);
      c_v = 4'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset();
      tick();
      for (int d = 0; d < ND; d++) begin
        checks++;
        if (get_act(d) !== exp_vec(d))
          $display("FAIL random_model dut%0d t=%0t got=%b need=%b", d, $time, get_act(d), exp_vec(d));
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_rotation();
    test_early_drop();
    test_back_to_back();
    test_async_reset();
    test_hold_one();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
